// File: rtl/calc_pkg.sv
// calc_pkg: shared display constants, hex segment table and scan FSM encoding
package calc_pkg;
    localparam int NUM_DIGITS = 4;
    // Active-low {g,f,e,d,c,b,a}, entry 15 first so HEX_SEG[h] selects digit h
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;
endpackage

// File: rtl/seg7_hex.sv
// seg7_hex: combinational 4-bit hex to active-low 7-segment decoder
module seg7_hex
    import calc_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[hex];
endmodule

// File: rtl/port_display_driver.sv
// port_display_driver: debounces CPU output ports into a snapshot and scans it
// onto a multiplexed 4-digit common-anode 7-segment display.
module port_display_driver
    import calc_pkg::*;
#(
    parameter int SCAN_DIV      = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            ps0,
    input  logic [7:0]            ps1,
    input  logic [7:0]            ps2,
    input  logic [7:0]            ps3,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  updated
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [31:0]   in_word, prev, snapshot;
    logic [CW-1:0] cnt;
    logic          stable, load;
    scan_state_t   state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [DW-1:0] div, div_nx;
    logic [7:0]    digit;
    logic [6:0]    seg;
    logic          show;

    assign in_word = {ps3, ps2, ps1, ps0};
    assign stable  = in_word == prev;
    assign load    = stable && cnt == CW'(STABLE_CYCLES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev     <= '0;
            cnt      <= '0;
            snapshot <= '0;
            updated  <= 1'b0;
        end else begin
            prev     <= in_word;
            cnt      <= !stable ? '0 : (cnt < CW'(STABLE_CYCLES)) ? cnt + CW'(1) : cnt;
            snapshot <= load ? in_word : snapshot;
            updated  <= load && in_word != snapshot;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_BLANK;
            idx   <= '0;
            div   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            div   <= div_nx;
        end
    end

    // BLANK is a single gap cycle; SHOW holds for SCAN_DIV cycles before advancing idx
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        div_nx   = div;
        if (state == ST_BLANK) begin
            state_nx = ST_SHOW;
            div_nx   = '0;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            state_nx = ST_BLANK;
            idx_nx   = idx + IW'(1);
        end else begin
            div_nx   = div + DW'(1);
        end
    end

    assign show  = state == ST_SHOW;
    assign digit = snapshot[{idx, 3'b000} +: 8];

    seg7_hex u_seg7_hex (
        .hex (digit[3:0]),
        .seg (seg)
    );

    assign an_n  = show ? ~(NUM_DIGITS'(1) << idx) : '1;
    assign seg_n = show ? seg : '1;
    assign dp_n  = show ? ~|digit[7:4] : 1'b1;
endmodule

// File: tb/tb_port_display_driver.sv
// tb_port_display_driver: randomized and directed checks against a value-age / frame-position model
module tb_port_display_driver;
    localparam int S = 8;
    localparam int D = 4;
    localparam int P = 4 * (D + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ps0 = '0, ps1 = '0, ps2 = '0, ps3 = '0;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n, updated;

    int total = 0;
    int bad = 0;

    // Model: how many edges the current value has been seen, and edges since reset release
    logic [31:0] m_last, m_snap;
    int          m_age, t;
    logic        m_upd;

    port_display_driver #(.SCAN_DIV(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .ps0(ps0), .ps1(ps1), .ps2(ps2), .ps3(ps3),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .updated(updated)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_last = '0;
            m_age  = 1;
            m_snap = '0;
            m_upd  = 1'b0;
            t      = 0;
        end else begin
            logic [31:0] in_now;
            in_now = {ps3, ps2, ps1, ps0};
            if (in_now != m_last) begin
                m_last = in_now;
                m_age  = 1;
            end else begin
                m_age++;
            end
            m_upd = 1'b0;
            if (m_age == S + 1) begin
                m_upd  = in_now != m_snap;
                m_snap = in_now;
            end
            t++;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic void exp_disp(output logic [3:0] ea, output logic [6:0] es, output logic ed);
        int p, d;
        logic [7:0] b;
        p = t % P;
        ea = 4'b1111; es = 7'h7F; ed = 1'b1;
        if (p % (D + 1) != 0) begin
            d  = p / (D + 1);
            b  = m_snap[8*d +: 8];
            ea = ~(4'b0001 << d);
            es = hex7(b[3:0]);
            ed = ~|b[7:4];
        end
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        #3;
        total++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || updated !== 1'b0) begin
            bad++;
            $display("FAIL reset: an_n=%b seg_n=%b dp_n=%b updated=%b want 1111 1111111 1 0", an_n, seg_n, dp_n, updated);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        logic [3:0] ea; logic [6:0] es; logic ed;
        int pulses = 0;
        ps0 = 8'h05; ps1 = 8'h00; ps2 = 8'h00; ps3 = 8'h00;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            exp_disp(ea, es, ed);
            total++;
            if (an_n !== ea || seg_n !== es || dp_n !== ed || updated !== m_upd) begin
                bad++;
                $display("FAIL basic c%0d: an=%b seg=%b dp=%b upd=%b want %b %b %b %b", i, an_n, seg_n, dp_n, updated, ea, es, ed, m_upd);
            end
            pulses += int'(updated);
            if (i == 8) begin
                total++;
                if (updated !== 1'b1) begin bad++; $display("FAIL basic_latency: updated=%b want 1 in cycle after edge 9", updated); end
            end
            if (i > 9 && an_n == 4'b1110) begin
                total++;
                if (seg_n !== 7'b0010010 || dp_n !== 1'b1) begin bad++; $display("FAIL basic_digit0: seg=%b dp=%b want 0010010 1", seg_n, dp_n); end
            end
            if (i > 9 && (an_n == 4'b1101 || an_n == 4'b1011 || an_n == 4'b0111)) begin
                total++;
                if (seg_n !== 7'b1000000) begin bad++; $display("FAIL basic_zero: an=%b seg=%b want 1000000", an_n, seg_n); end
            end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_glitch;
        logic [3:0] ea; logic [6:0] es; logic ed;
        int pulses = 0;
        ps1 = 8'h05;
        for (int i = 0; i < 72; i++) begin
            if (i == 15) ps1 = 8'h07;
            if (i == 18) ps1 = 8'h05;
            if (i == 35) ps1 = 8'h07;
            if (i == 14 || i == 35) pulses = 0;
            @(negedge clk);
            exp_disp(ea, es, ed);
            total++;
            if (an_n !== ea || seg_n !== es || dp_n !== ed || updated !== m_upd) begin
                bad++;
                $display("FAIL glitch c%0d: an=%b seg=%b dp=%b upd=%b want %b %b %b %b", i, an_n, seg_n, dp_n, updated, ea, es, ed, m_upd);
            end
            pulses += int'(updated);
            if (i >= 15 && i < 35 && an_n == 4'b1101) begin
                total++;
                if (seg_n !== 7'b0010010) begin bad++; $display("FAIL glitch_hold: seg=%b want 0010010", seg_n); end
            end
            if (i == 34) begin
                total++;
                if (pulses != 0) begin bad++; $display("FAIL glitch_nopulse: got %0d want 0", pulses); end
            end
            if (i > 55 && an_n == 4'b1101) begin
                total++;
                if (seg_n !== 7'b1111000) begin bad++; $display("FAIL glitch_new: seg=%b want 1111000", seg_n); end
            end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL glitch_accept: got %0d pulses want 1", pulses); end
    endtask

    task automatic test_high_nibble;
        logic [3:0] ea; logic [6:0] es; logic ed;
        ps2 = 8'h13;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            exp_disp(ea, es, ed);
            total++;
            if (an_n !== ea || seg_n !== es || dp_n !== ed || updated !== m_upd) begin
                bad++;
                $display("FAIL high c%0d: an=%b seg=%b dp=%b upd=%b want %b %b %b %b", i, an_n, seg_n, dp_n, updated, ea, es, ed, m_upd);
            end
            if (i > 15 && an_n == 4'b1011) begin
                total++;
                if (seg_n !== 7'b0110000 || dp_n !== 1'b0) begin bad++; $display("FAIL high_digit2: seg=%b dp=%b want 0110000 0", seg_n, dp_n); end
            end
        end
    endtask

    task automatic test_settle_back;
        logic [3:0] ea; logic [6:0] es; logic ed;
        logic [7:0] keep;
        int pulses = 0;
        keep = ps3;
        for (int i = 0; i < 25; i++) begin
            if (i == 2) ps3 = keep ^ 8'h5A;
            if (i == 5) ps3 = keep;
            @(negedge clk);
            exp_disp(ea, es, ed);
            total++;
            if (an_n !== ea || seg_n !== es || dp_n !== ed || updated !== m_upd) begin
                bad++;
                $display("FAIL settle c%0d: an=%b seg=%b dp=%b upd=%b want %b %b %b %b", i, an_n, seg_n, dp_n, updated, ea, es, ed, m_upd);
            end
            pulses += int'(updated);
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL settle_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_random;
        logic [3:0] ea; logic [6:0] es; logic ed;
        int hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                hold = $urandom_range(14, 1);
                case ($urandom_range(3, 0))
                    0: ps0 = 8'($urandom);
                    1: ps1 = 8'($urandom);
                    2: ps2 = 8'($urandom);
                    default: ps3 = 8'($urandom);
                endcase
            end
            hold--;
            @(negedge clk);
            exp_disp(ea, es, ed);
            total++;
            if (an_n !== ea || seg_n !== es || dp_n !== ed || updated !== m_upd) begin
                bad++;
                $display("FAIL random c%0d: an=%b seg=%b dp=%b upd=%b want %b %b %b %b", i, an_n, seg_n, dp_n, updated, ea, es, ed, m_upd);
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        logic [3:0] ea; logic [6:0] es; logic ed;
        int pulses = 0;
        int n = 0;
        ps0 = 8'h05; ps1 = 8'h07; ps2 = 8'h13; ps3 = 8'h2C;
        while (an_n !== 4'b1011 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (an_n !== 4'b1011) begin bad++; $display("FAIL reset_wait: digit 2 never lit, an=%b", an_n); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || updated !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: an=%b seg=%b dp=%b upd=%b want 1111 1111111 1 0", an_n, seg_n, dp_n, updated);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            exp_disp(ea, es, ed);
            total++;
            if (an_n !== ea || seg_n !== es || dp_n !== ed || updated !== m_upd) begin
                bad++;
                $display("FAIL reset_resume c%0d: an=%b seg=%b dp=%b upd=%b want %b %b %b %b", i, an_n, seg_n, dp_n, updated, ea, es, ed, m_upd);
            end
            if (i == 0) begin
                total++;
                if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin bad++; $display("FAIL reset_restart: an=%b seg=%b want 1110 1000000", an_n, seg_n); end
            end
            pulses += int'(updated);
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL reset_reload: got %0d pulses want 1", pulses); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_high_nibble;
        test_settle_back;
        test_random;
        test_reset_mid_scan;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
